apb4_mem_slave: RTL and testbench

Parametrised APB4 completer: a byte-strobed register/memory bank with configurable data width, depth and wait states, plus error signalling for bad addresses and aborted transfers. It is the drop-in successor to the 8-bit fixed-depth APB slave on the peripheral bus. It sits behind the APB decoder as a scratch/config memory and drives `pready`/`pslverr` from an explicit SETUP/ACCESS state machine.

---
 rtl/apb_pkg.sv | 47 ++++
 rtl/apb_strb_ram.sv | 50 +++++
 rtl/apb4_mem_slave.sv | 145 ++++++++++++++
 tb/tb_apb4_mem_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB4 memory completer:
//   - apb_state_t : transfer FSM states (IDLE / ACCESS)
//   - apb_clog2   : ceiling log2 usable in constant expressions
//   - width helpers for strobe lanes, byte-offset bits, index and counter widths
//   - default data width, strobe width and byte-offset width
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  function automatic int apb_clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Number of byte lanes in a data word.
  function automatic int apb_strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Byte-offset bits inside a word (BL).
  function automatic int apb_bl(input int data_w);
    return apb_clog2(data_w / 8);
  endfunction

  // Word index width; never narrower than one bit.
  function automatic int apb_idx_w(input int depth);
    return (apb_clog2(depth) < 1) ? 1 : apb_clog2(depth);
  endfunction

  // Wait counter width able to hold WAIT_STATES; never narrower than one bit.
  function automatic int apb_cnt_w(input int wait_states);
    return (apb_clog2(wait_states + 1) < 1) ? 1 : apb_clog2(wait_states + 1);
  endfunction

  localparam int APB_DEF_DATA_W = 32;
  localparam int APB_DEF_STRB_W = APB_DEF_DATA_W / 8;
  localparam int APB_DEF_BL     = 2;

endpackage

// File: rtl/apb_strb_ram.sv
// -----------------------------------------------------------------------------
// apb_strb_ram
// DEPTH x DATA_W storage with asynchronous clear, per-byte write enables and a
// combinational read port sharing the same word index.
// Ports:
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low clear of every word
//   i_idx     : word index for both read and write
//   i_wr_be   : per-byte write enable (one bit per byte lane)
//   i_wr_data : write data
//   o_rd_data : combinational read data (0 for an index beyond DEPTH)
// -----------------------------------------------------------------------------
module apb_strb_ram
  import apb_pkg::*;
#(
  parameter int DATA_W = APB_DEF_DATA_W,
  parameter int STRB_W = APB_DEF_STRB_W,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [STRB_W-1:0] i_wr_be,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  // One extra bit so DEPTH itself is representable when DEPTH == 2**IDX_W.
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_in_range;

  assign w_in_range = ({1'b0, i_idx} < DEPTH_V);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int w = 0; w < DEPTH; w++) r_mem[w] <= '0;
    end else if (w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wr_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
  end

  // Non-power-of-two depths leave holes in the index space; read those as 0.
  assign o_rd_data = w_in_range ? r_mem[i_idx] : '0;

endmodule

// File: rtl/apb4_mem_slave.sv
// -----------------------------------------------------------------------------
// apb4_mem_slave
// APB4 completer fronting a byte-strobed memory of DEPTH words of DATA_W bits.
// Transfers go IDLE -> ACCESS on a SETUP cycle; the request is latched there and
// the bus is not looked at again except for psel/penable/slave_wait. ACCESS
// completes after WAIT_STATES cycles once slave_wait is low, or aborts if the
// master drops psel/penable first. Misaligned or out-of-range addresses complete
// with pslverr and leave memory untouched.
// Ports:
//   pclk, presetn            : clock (rising edge), async active-low reset
//   psel, penable, pwrite    : APB control
//   paddr, pwdata, pstrb     : byte address, write data, write byte strobes
//   slave_wait               : external stall holding off pready
//   prdata, pready, pslverr  : combinational response (0 unless pready)
//   abort                    : registered one-cycle pulse on an aborted ACCESS
// -----------------------------------------------------------------------------
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = APB_DEF_DATA_W,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [apb_strb_w(DATA_W)-1:0] pstrb,
  input  logic                       slave_wait,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic                       abort
);

  localparam int STRB_W = apb_strb_w(DATA_W);
  localparam int BL     = apb_bl(DATA_W);
  localparam int IDX_W  = apb_idx_w(DEPTH);
  localparam int CNT_W  = apb_cnt_w(WAIT_STATES);

  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((64'd1 << BL) - 64'd1);

  apb_state_t        r_state;
  apb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_abort;

  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_strb;

  logic              w_setup;
  logic              w_done;
  logic              w_drop;
  logic [ADDR_W-1:0] w_idx;
  logic              w_misalign;
  logic              w_range;
  logic              w_err;
  logic [STRB_W-1:0] w_we;
  logic [DATA_W-1:0] w_rd_data;

  assign w_setup = psel && !penable;
  assign w_done  = (r_state == ACCESS) && psel && penable &&
                   (r_cnt == '0) && !slave_wait;
  assign w_drop  = (r_state == ACCESS) && !(psel && penable);

  assign w_idx      = r_addr >> BL;
  assign w_misalign = |(r_addr & LANE_MASK);
  assign w_range    = (w_idx >= ADDR_W'(DEPTH));
  assign w_err      = w_misalign || w_range;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_drop;
    end
  end

  // Request copy is pure data: it is only consulted in ACCESS, which is always
  // entered through a SETUP cycle that loads it.
  always_ff @(posedge pclk) begin
    if ((r_state == IDLE) && w_setup) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        // psel && penable without a preceding SETUP is ignored here.
        if (w_setup) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        // Wait states run down even while slave_wait is asserted.
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        if (w_done || w_drop) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_we = (w_done && r_write && !w_err) ? r_strb : '0;

  apb_strb_ram #(
    .DATA_W (DATA_W),
    .STRB_W (STRB_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .i_clk     (pclk),
    .i_rst_n   (presetn),
    .i_idx     (w_idx[IDX_W-1:0]),
    .i_wr_be   (w_we),
    .i_wr_data (r_wdata),
    .o_rd_data (w_rd_data)
  );

  assign pready  = w_done;
  assign pslverr = w_done && w_err;
  assign prdata  = (w_done && !r_write && !w_err) ? w_rd_data : '0;
  assign abort   = r_abort;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Three completers on one bus, each with its own psel:
//   index 0 -> WAIT_STATES=0, index 1 -> WAIT_STATES=2, index 2 -> WAIT_STATES=3.
module tb_apb4_mem_slave;

  logic        pclk;
  logic        presetn;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        slave_wait;

  logic [31:0] prdata_v [3];
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [2:0]  abort_v;

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb4_mem_slave #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .DEPTH       (16),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .psel       (psel_v[g]),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .pstrb      (pstrb),
      .slave_wait (slave_wait),
      .prdata     (prdata_v[g]),
      .pready     (pready_v[g]),
      .pslverr    (pslverr_v[g]),
      .abort      (abort_v[g])
    );
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One APB transfer on completer s. SETUP is cycle T; lat is the number of
  // cycles from T to the cycle with pready (1 for a zero-wait transfer).
  // slave_wait is held high in cycles T+1 .. T+nwait. Returns at the negedge of
  // the completion cycle with psel/penable still high.
  task automatic apb_xfer(input int s, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st, input int nwait,
                          output logic [31:0] rd, output logic err, output int lat);
    bit fin;
    rd  = '0;
    err = 1'b0;
    fin = 1'b0;
    @(posedge pclk); #1;
    psel_v     = '0;
    psel_v[s]  = 1'b1;
    penable    = 1'b0;
    pwrite     = wr;
    paddr      = a;
    pwdata     = d;
    pstrb      = st;
    slave_wait = 1'b0;
    @(posedge pclk); #1;
    lat        = 1;
    penable    = 1'b1;
    slave_wait = (nwait >= 1);
    while (!fin) begin
      @(negedge pclk);
      if (pready_v[s]) begin
        rd  = prdata_v[s];
        err = pslverr_v[s];
        fin = 1'b1;
      end else if (lat >= 20) begin
        check_eq("pready_timeout", 32'(pready_v[s]), 32'd1);
        lat = -1;
        fin = 1'b1;
      end else begin
        @(posedge pclk); #1;
        lat++;
        slave_wait = (lat <= nwait);
      end
    end
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel_v     = '0;
    penable    = 1'b0;
    slave_wait = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    presetn    = 1'b0;
    psel_v     = '0;
    penable    = 1'b0;
    pwrite     = 1'b0;
    paddr      = '0;
    pwdata     = '0;
    pstrb      = '0;
    slave_wait = 1'b0;

    repeat (2) @(negedge pclk);
    check_eq("rst_pready",  32'(pready_v),  32'd0);
    check_eq("rst_pslverr", 32'(pslverr_v), 32'd0);
    check_eq("rst_abort",   32'(abort_v),   32'd0);
    check_eq("rst_prdata",  prdata_v[0],    32'd0);
    presetn = 1'b1;

    // Full write then read, back to back (2 cycles per transfer).
    apb_xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check_eq("wr08_lat", 32'(lat), 32'd1);
    check_eq("wr08_err", 32'(er),  32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("rd08_lat",  32'(lat), 32'd1);
    check_eq("rd08_data", rd,       32'hDEADBEEF);
    check_eq("rd08_err",  32'(er),  32'd0);

    // Partial strobe write over stored word.
    apb_xfer(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 0, rd, er, lat);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("strb_data", rd, 32'hDE22BE44);

    // Zero strobe completes without error and changes nothing.
    apb_xfer(0, 1'b1, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("strb0_err", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, 0, rd, er, lat);
    check_eq("strb0_data", rd, 32'hDE22BE44);
    bus_idle();

    // Out of range (idx 16) and misaligned accesses.
    apb_xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    check_eq("range_wr_lat", 32'(lat), 32'd1);
    check_eq("range_wr_err", 32'(er),  32'd1);
    apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("range_rd_err",  32'(er), 32'd1);
    check_eq("range_rd_data", rd,      32'd0);
    apb_xfer(0, 1'b1, 32'h06, 32'h12345678, 4'hF, 0, rd, er, lat);
    check_eq("mis_wr_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b0, 32'h06, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("mis_rd_err",  32'(er), 32'd1);
    check_eq("mis_rd_data", rd,      32'd0);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("mis_nowr_04", rd, 32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("mis_nowr_08", rd, 32'hDE22BE44);
    check_eq("no_abort0", 32'(abort_v[0]), 32'd0);
    bus_idle();

    // WAIT_STATES=2 with slave_wait high for T+1..T+3, last valid word.
    apb_xfer(1, 1'b1, 32'h3C, 32'hA5A55A5A, 4'hF, 3, rd, er, lat);
    check_eq("ws2_wr_lat", 32'(lat), 32'd4);
    check_eq("ws2_wr_err", 32'(er),  32'd0);
    apb_xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("ws2_rd_lat",  32'(lat), 32'd3);
    check_eq("ws2_rd_data", rd,       32'hA5A55A5A);
    bus_idle();

    // WAIT_STATES=3: penable dropped in the first ACCESS cycle.
    @(posedge pclk); #1;
    psel_v  = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'h0BADF00D;
    pstrb   = 4'hF;
    @(posedge pclk); #1;
    @(negedge pclk);
    check_eq("abt_pready", 32'(pready_v[2]), 32'd0);
    check_eq("abt_pre",    32'(abort_v[2]),  32'd0);
    @(posedge pclk); #1;
    psel_v = '0;
    @(negedge pclk);
    check_eq("abt_pulse", 32'(abort_v[2]), 32'd1);
    @(negedge pclk);
    check_eq("abt_end", 32'(abort_v[2]), 32'd0);
    apb_xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("abt_rd_lat",  32'(lat), 32'd4);
    check_eq("abt_nowr",    rd,       32'd0);
    apb_xfer(2, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    check_eq("abt_next_err", 32'(er), 32'd0);
    apb_xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("abt_next_data", rd, 32'hCAFEF00D);
    check_eq("abt_none", 32'(abort_v[2]), 32'd0);
    bus_idle();

    // Reset asserted during ACCESS of a write, before the commit edge.
    @(posedge pclk); #1;
    psel_v  = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0C;
    pwdata  = 32'h55AA55AA;
    pstrb   = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1 presetn = 1'b0;
    #1;
    check_eq("mrst_pready",  32'(pready_v[0]),  32'd0);
    check_eq("mrst_pslverr", 32'(pslverr_v[0]), 32'd0);
    check_eq("mrst_prdata",  prdata_v[0],       32'd0);
    check_eq("mrst_abort",   32'(abort_v[0]),   32'd0);
    bus_idle();
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check_eq("mrst_abort_after", 32'(abort_v[0]), 32'd0);
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("mrst_word0C", rd, 32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
    check_eq("mrst_word08", rd, 32'd0);
    bus_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
